// File: rtl/peripheral_counter_core.sv
// Counter/config/status storage behind the native register interface, with a prescaled
// up/down counter and a sticky wrap interrupt (built only when PERIPHERAL_COUNTER_IRQ_EN is defined).
module peripheral_counter_core #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] LT_LIMIT = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_in,
  input  logic        config_we,
  input  logic        en_in,
  input  logic        dir_in,
  input  logic        ire_in,
  output logic [31:0] count_out,
  output logic        en_out,
  output logic        dir_out,
  output logic        ire_out,
  output logic        lt_1k_out,
  output logic        irq
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [31:0] count_q, count_d;
  logic        en_q, en_d;
  logic        dir_q, dir_d;
  logic [15:0] pre_q, pre_d;
  logic        step_due;
  logic        wrap_event;

  assign step_due = en_q && (pre_q == PRE_LAST);

  // A counter write discards the coincident step, so it cannot produce a wrap.
  assign wrap_event = step_due && !count_we &&
                      (dir_q ? (count_q == 32'hFFFF_FFFF) : (count_q == 32'h0000_0000));

  always_comb begin
    pre_d = pre_q + 16'd1;
    if (count_we || config_we || !en_q || step_due) begin
      pre_d = 16'd0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (count_we) begin
      count_d = count_in;
    end else if (step_due) begin
      count_d = dir_q ? (count_q + 32'd1) : (count_q - 32'd1);
    end
  end

  always_comb begin
    en_d  = en_q;
    dir_d = dir_q;
    if (config_we) begin
      en_d  = en_in;
      dir_d = dir_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
      en_q    <= 1'b0;
      dir_q   <= 1'b1;
      pre_q   <= 16'd0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
    end
  end

`ifdef PERIPHERAL_COUNTER_IRQ_EN
  logic ire_q, ire_d;
  logic irq_q, irq_d;

  always_comb begin
    ire_d = config_we ? ire_in : ire_q;
    irq_d = irq_q;
    if (config_we) begin
      irq_d = 1'b0;
    end
    // Set beats clear; the pre-write ire_q gates the event.
    if (wrap_event && ire_q) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ire_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ire_q <= ire_d;
      irq_q <= irq_d;
    end
  end

  assign ire_out = ire_q;
  assign irq     = irq_q;
`else
  logic ire_in_unused;
  logic wrap_event_unused;

  assign ire_in_unused     = ire_in;
  assign wrap_event_unused = wrap_event;
  assign ire_out           = 1'b0;
  assign irq               = 1'b0;
`endif

  assign count_out = count_q;
  assign en_out    = en_q;
  assign dir_out   = dir_q;
  assign lt_1k_out = (count_q < LT_LIMIT);

endmodule

// File: tb/tb_peripheral_counter_core.sv
// Directed bench for peripheral_counter_core: one PRESCALE=4 and one PRESCALE=1 instance.
module tb_peripheral_counter_core;

`ifdef PERIPHERAL_COUNTER_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cwe4 = 0, gwe4 = 0, en4 = 0, dir4 = 0, ire4 = 0;
  logic [31:0] cin4 = 0;
  logic [31:0] cnt4;
  logic        eno4, diro4, ireo4, lt4, irq4;

  logic        cwe1 = 0, gwe1 = 0, en1 = 0, dir1 = 0, ire1 = 0;
  logic [31:0] cin1 = 0;
  logic [31:0] cnt1;
  logic        eno1, diro1, ireo1, lt1, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  peripheral_counter_core #(.PRESCALE(4), .LT_LIMIT(32'd1000)) u_p4 (
    .clk(clk), .reset(reset), .count_we(cwe4), .count_in(cin4), .config_we(gwe4),
    .en_in(en4), .dir_in(dir4), .ire_in(ire4), .count_out(cnt4), .en_out(eno4),
    .dir_out(diro4), .ire_out(ireo4), .lt_1k_out(lt4), .irq(irq4)
  );

  peripheral_counter_core #(.PRESCALE(1), .LT_LIMIT(32'd1000)) u_p1 (
    .clk(clk), .reset(reset), .count_we(cwe1), .count_in(cin1), .config_we(gwe1),
    .en_in(en1), .dir_in(dir1), .ire_in(ire1), .count_out(cnt1), .en_out(eno1),
    .dir_out(diro1), .ire_out(ireo1), .lt_1k_out(lt1), .irq(irq1)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    check("rst4_count", cnt4, 32'd0);
    check("rst4_en", 32'(eno4), 32'd0);
    check("rst4_dir", 32'(diro4), 32'd1);
    check("rst4_ire", 32'(ireo4), 32'd0);
    check("rst4_lt", 32'(lt4), 32'd1);
    check("rst4_irq", 32'(irq4), 32'd0);
    check("rst1_count", cnt1, 32'd0);
    check("rst1_dir", 32'(diro1), 32'd1);

    // Up counting, PRESCALE=4: config in cycle N
    cwe4 = 1; cin4 = 32'd998;
    tick();
    cwe4 = 0;
    gwe4 = 1; en4 = 1; dir4 = 1; ire4 = 0;
    tick();                               // N+1
    gwe4 = 0;
    check("up_n1_count", cnt4, 32'd998);
    check("up_n1_en", 32'(eno4), 32'd1);
    tick(3);                              // N+4
    check("up_n4_count", cnt4, 32'd998);
    tick();                               // N+5
    check("up_n5_count", cnt4, 32'd999);
    check("up_n5_lt", 32'(lt4), 32'd1);
    tick(3);                              // N+8
    check("up_n8_count", cnt4, 32'd999);
    check("up_n8_lt", 32'(lt4), 32'd1);
    tick();                               // N+9
    check("up_n9_count", cnt4, 32'd1000);
    check("up_n9_lt", 32'(lt4), 32'd0);

    // Write priority: count_we in the cycle a step is due (N+12)
    tick(3);
    cwe4 = 1; cin4 = 32'h1234_5678;
    tick();                               // N+13
    cwe4 = 0;
    check("pri_load", cnt4, 32'h1234_5678);
    tick(3);                              // N+16
    check("pri_hold", cnt4, 32'h1234_5678);
    tick();                               // N+17
    check("pri_step", cnt4, 32'h1234_5679);

    // Wrap coincident with a config write
    cwe4 = 1; cin4 = 32'hFFFF_FFFF;
    gwe4 = 1; en4 = 1; dir4 = 1; ire4 = 1;
    tick();                               // A+1
    cwe4 = 0; gwe4 = 0;
    check("cw_load", cnt4, 32'hFFFF_FFFF);
    check("cw_ire", 32'(ireo4), 32'(IRQ_BUILT));
    tick(3);                              // A+4: step due
    check("cw_pre_irq", 32'(irq4), 32'd0);
    gwe4 = 1; en4 = 1; dir4 = 1; ire4 = 1;
    tick();                               // A+5
    gwe4 = 0;
    check("cw_count", cnt4, 32'd0);
    check("cw_irq", 32'(irq4), 32'(IRQ_BUILT));
    gwe4 = 1; en4 = 0; dir4 = 1; ire4 = 0;
    tick();
    gwe4 = 0;
    check("cw_clear_irq", 32'(irq4), 32'd0);

    // Down wrap with interrupt, PRESCALE=1
    cwe1 = 1; cin1 = 32'd1;
    gwe1 = 1; en1 = 1; dir1 = 0; ire1 = 1;
    tick();                               // B+1
    cwe1 = 0; gwe1 = 0;
    check("dw_b1_count", cnt1, 32'd1);
    check("dw_b1_ire", 32'(ireo1), 32'(IRQ_BUILT));
    check("dw_b1_irq", 32'(irq1), 32'd0);
    tick();                               // B+2
    check("dw_b2_count", cnt1, 32'd0);
    check("dw_b2_irq", 32'(irq1), 32'd0);
    tick();                               // B+3
    check("dw_b3_count", cnt1, 32'hFFFF_FFFF);
    check("dw_b3_lt", 32'(lt1), 32'd0);
    tick();                               // B+4
    check("dw_b4_count", cnt1, 32'hFFFF_FFFE);
    check("dw_b4_irq", 32'(irq1), 32'(IRQ_BUILT));
    tick();
    check("dw_b5_irq_hold", 32'(irq1), 32'(IRQ_BUILT));
    check("dw_b5_ire", 32'(ireo1), 32'(IRQ_BUILT));
    gwe1 = 1; en1 = 0; dir1 = 0; ire1 = 1;
    tick();
    gwe1 = 0;
    check("dw_clear_irq", 32'(irq1), 32'd0);
    check("dw_clear_en", 32'(eno1), 32'd0);
    check("dw_clear_ire", 32'(ireo1), 32'(IRQ_BUILT));

    // Reset mid-count overrides a same-cycle write
    gwe1 = 1; en1 = 1; dir1 = 0; ire1 = 1;
    tick();
    gwe1 = 0;
    tick(2);
    reset = 1; cwe1 = 1; cin1 = 32'hDEAD_BEEF;
    tick();
    reset = 0; cwe1 = 0;
    check("mid_rst_count", cnt1, 32'd0);
    check("mid_rst_en", 32'(eno1), 32'd0);
    check("mid_rst_dir", 32'(diro1), 32'd1);
    check("mid_rst_ire", 32'(ireo1), 32'd0);
    tick(2);
    check("mid_rst_idle", cnt1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
